// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_unit
// Purpose  : Pending-write scoreboard, RAW/memory stall control, EX bubble
//            insertion and stall watchdog for a 5-stage pipeline.
//            Optional macro HAZARD_PERF_EN adds a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int NREG      = 32,
    parameter int REG_W     = 5,
    parameter int STALL_MAX = 255,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic             id_rs1_used,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_rd_we,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             write_enable,
    output logic             bubble,
    output logic             deadlock,
    output logic [CNT_W-1:0] stall_count
);

    localparam int c_RUN_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(STALL_MAX);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

    logic [NREG-1:0]    r_pending_q;
    logic [NREG-1:0]    w_pending_d;
    logic [c_RUN_W-1:0] r_run_q;
    logic [c_RUN_W-1:0] w_run_d;
    logic               r_deadlock_q;
    logic               w_deadlock_d;

    logic [NREG-1:0]    w_wb_clr;
    logic [NREG-1:0]    w_eff;
    logic [NREG-1:0]    w_rs1_sel;
    logic [NREG-1:0]    w_rs2_sel;
    logic [NREG-1:0]    w_rd_sel;
    logic               w_raw;
    logic               w_issue;

    // One-hot decoders only cover real registers above r0, so r0 and any
    // out-of-range index can never hazard nor be marked pending.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign w_wb_clr[gi]  = 1'b0;
            assign w_rs1_sel[gi] = 1'b0;
            assign w_rs2_sel[gi] = 1'b0;
            assign w_rd_sel[gi]  = 1'b0;
        end else begin : g_nonzero
            assign w_wb_clr[gi]  = wb_valid & wb_we & (wb_rd == REG_W'(gi));
            assign w_rs1_sel[gi] = (id_rs1 == REG_W'(gi));
            assign w_rs2_sel[gi] = (id_rs2 == REG_W'(gi));
            assign w_rd_sel[gi]  = (id_rd == REG_W'(gi));
        end
    end

    // A write retiring this cycle is already visible to ID's register read.
    assign w_eff = r_pending_q & ~w_wb_clr;

    assign w_raw = id_valid & ~flush &
                   ((id_rs1_used & (|(w_eff & w_rs1_sel))) |
                    (id_rs2_used & (|(w_eff & w_rs2_sel))));

    assign write_enable = rst | (~mem_busy & ~w_raw);
    assign bubble       = ~rst & w_raw & ~mem_busy;
    assign deadlock     = r_deadlock_q;

    assign w_issue = id_valid & ~flush & write_enable & id_rd_we & (|w_rd_sel);

    always_comb begin
        w_pending_d  = w_eff | (w_issue ? w_rd_sel : '0);
        w_run_d      = '0;
        w_deadlock_d = r_deadlock_q;
        if (!write_enable) begin
            w_run_d = (r_run_q == c_RUN_MAX) ? r_run_q : r_run_q + c_RUN_ONE;
        end
        if (w_run_d == c_RUN_MAX && !write_enable) begin
            w_deadlock_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending_q  <= '0;
            r_run_q      <= '0;
            r_deadlock_q <= 1'b0;
        end else begin
            r_pending_q  <= w_pending_d;
            r_run_q      <= w_run_d;
            r_deadlock_q <= w_deadlock_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] w_stall_cnt_d;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (!write_enable && r_stall_cnt_q != '1) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall_count = r_stall_cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_stall_unit
// Purpose  : Directed scoreboard bench for hazard_stall_unit (STALL_MAX = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_EN
    localparam bit c_PERF = 1'b1;
`else
    localparam bit c_PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_rs1_used, id_rs2_used, id_rd_we;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        wb_valid, wb_we, mem_busy, flush;
    logic        write_enable, bubble, deadlock;
    logic [15:0] stall_count;

    int tests = 0;
    int fails = 0;

    logic [18:0] exp_q[$];
    string       name_q[$];

    always #5 clk = ~clk;

    hazard_stall_unit #(
        .NREG(32), .REG_W(5), .STALL_MAX(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_rd_we(id_rd_we),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we),
        .mem_busy(mem_busy), .flush(flush),
        .write_enable(write_enable), .bubble(bubble),
        .deadlock(deadlock), .stall_count(stall_count)
    );

    // Monitor: compares one expected record per cycle, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [18:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if ({write_enable, bubble, deadlock, stall_count} !== e) begin
                fails++;
                $display("FAIL %s: got we=%b bub=%b dl=%b sc=%0d, expected we=%b bub=%b dl=%b sc=%0d",
                         n, write_enable, bubble, deadlock, stall_count,
                         e[18], e[17], e[16], e[15:0]);
            end
        end
    end

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_rd_we = 0; wb_valid = 0; wb_rd = 0; wb_we = 0;
        mem_busy = 0; flush = 0;
    endtask

    task automatic set_id(input logic [4:0] rs1, input logic rs1u,
                          input logic [4:0] rs2, input logic rs2u,
                          input logic [4:0] rd, input logic rdwe);
        id_valid = 1; id_rs1 = rs1; id_rs1_used = rs1u;
        id_rs2 = rs2; id_rs2_used = rs2u; id_rd = rd; id_rd_we = rdwe;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] rd);
        wb_valid = v; wb_we = v; wb_rd = rd;
    endtask

    // Push the expected outputs for the current cycle, then advance one cycle.
    task automatic step(input string n, input logic we, input logic bub,
                        input logic dl, input int sc);
        logic [15:0] sce;
        sce = c_PERF ? 16'(sc) : 16'd0;
        exp_q.push_back({we, bub, dl, sce});
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string n);
        rst = 1;
        idle();
        @(posedge clk);
        #1;
        step(n, 1, 0, 0, 0);
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        // 1: basic RAW stall released by same-cycle WB
        do_reset("reset");
        set_id(0, 0, 0, 0, 5, 1);             step("t1_issue_r5", 1, 0, 0, 0);
        set_id(5, 1, 0, 0, 0, 0);             step("t1_raw_c1",   0, 1, 0, 0);
                                              step("t1_raw_c2",   0, 1, 0, 1);
        set_wb(1, 5);                         step("t1_wb_clear", 1, 0, 0, 2);
        set_wb(0, 0);                         step("t1_after_wb", 1, 0, 0, 2);

        // 2: r0 never pending
        do_reset("t2_reset");
        set_id(0, 0, 0, 0, 0, 1);             step("t2_issue_r0", 1, 0, 0, 0);
        set_id(0, 1, 0, 1, 0, 0);             step("t2_read_r0",  1, 0, 0, 0);

        // 3: mem_busy freezes and masks the bubble
        do_reset("t3_reset");
        idle(); set_id(0, 0, 0, 0, 7, 1);     step("t3_issue_r7", 1, 0, 0, 0);
        set_id(0, 0, 7, 1, 0, 0); mem_busy=1; step("t3_busy_raw", 0, 0, 0, 0);
        mem_busy = 0;                         step("t3_bubble",   0, 1, 0, 1);
        set_wb(1, 7);                         step("t3_wb_r7",    1, 0, 0, 2);

        // 4: same-cycle clear and set keeps register pending
        do_reset("t4_reset");
        set_id(0, 0, 0, 0, 9, 1);             step("t4_issue_r9", 1, 0, 0, 0);
        set_wb(1, 9);                         step("t4_clr_set",  1, 0, 0, 0);
        set_wb(0, 0); set_id(9, 1, 0, 0, 0, 0); step("t4_read_r9", 0, 1, 0, 0);
        set_wb(1, 9);                         step("t4_release",  1, 0, 0, 1);

        // 5: flush squashes hazard and issue
        do_reset("t5_reset");
        set_id(0, 0, 0, 0, 4, 1);             step("t5_issue_r4", 1, 0, 0, 0);
        set_id(4, 1, 0, 0, 3, 1); flush = 1;  step("t5_flush",    1, 0, 0, 0);
        flush = 0; set_id(3, 1, 0, 0, 0, 0);  step("t5_r3_clean", 1, 0, 0, 0);
        set_id(0, 0, 4, 1, 0, 0);             step("t5_r4_still", 0, 1, 0, 0);
        set_wb(1, 4);                         step("t5_release",  1, 0, 0, 1);

        // 6: watchdog at STALL_MAX = 4, sticky until reset
        do_reset("t6_reset");
        set_id(0, 0, 0, 0, 6, 1);             step("t6_issue_r6", 1, 0, 0, 0);
        set_id(6, 1, 0, 0, 0, 0);             step("t6_stall_c1", 0, 1, 0, 0);
                                              step("t6_stall_c2", 0, 1, 0, 1);
                                              step("t6_stall_c3", 0, 1, 0, 2);
                                              step("t6_stall_c4", 0, 1, 0, 3);
        set_wb(1, 6);                         step("t6_deadlock", 1, 0, 1, 4);
        idle();                               step("t6_sticky",   1, 0, 1, 4);
        do_reset("t6_rst_clear");
        idle();                               step("t6_post_rst", 1, 0, 0, 0);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d records left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
